tile_lane_queue: RTL and testbench
==================================

// Module: tile_lane_queue
// PURPOSE
//   Downstream consumer of the lane-select stage. Each state_change pulse pushes the
//   4-bit one-hot lane word in as a new top row of a ROWS-deep falling-tile queue and
//   scrolls all rows down by one. Player key presses are scored against the bottom
//   (hit) row. Outputs are the row image for the display stage plus score, miss count
//   and game-over status.
// PARAMETERS
//   ROWS     8   rows in the queue; row 0 is the top, row ROWS-1 is the hit row
//   SCORE_W  10  score width; the score saturates at 2**SCORE_W-1
//   MAX_MISS 3   miss count that ends the game (1..15)
// PORTS
//   clk          in   1       system clock
//   rst          in   1       asynchronous, active-high reset
//   state        in   4       one-hot lane of the next tile; sampled only when state_change=1
//   state_change in   1       1-cycle push/scroll strobe
//   btn          in   4       key levels, already synchronised and debounced; bit i = lane i
//   start        in   1       level; starts a game from IDLE or from OVER
//   rows_flat    out  4*ROWS  row r occupies bits [4r+3:4r]
//   score        out  SCORE_W number of hits
//   misses       out  4       number of misses
//   hit_pulse    out  1       1-cycle pulse on a hit
//   miss_pulse   out  1       1-cycle pulse on a miss
//   game_over    out  1       high while in OVER
// BEHAVIOUR
//   Reset: FSM=IDLE; all rows, score, misses, pulses, game_over and btn_q are 0.
//   FSM IDLE: queue frozen, presses ignored. start=1 -> PLAY.
//   FSM PLAY: runs the queue and scoring. misses reaching MAX_MISS -> OVER.
//   FSM OVER: game_over=1; queue, score and misses are frozen and held.
//     start=1 -> clear rows, score and misses, then go to PLAY.
//   Edge detect: btn_q <= btn every cycle. press = btn & ~btn_q.
//     All outputs are registered, so the response appears one cycle after the press.
//   Push (PLAY && state_change):
//     row[0] <= state if state is one-hot, otherwise row[0] <= 4'b0000.
//     row[i] <= row[i-1] for i = 1..ROWS-1.
//     The old hit row is discarded. If it was non-zero and not hit this cycle, that is a miss.
//   Press (PLAY && press != 0), evaluated against the pre-shift hit row:
//     press == hit row, and hit row != 0 -> hit:
//       hit_pulse=1; score+1 (saturating); the hit row is cleared.
//       If a push occurs in the same cycle, the push still shifts, but no miss is
//       counted for the departing row.
//     Any other non-zero press -> miss:
//       covers a wrong lane, multiple keys, or an empty hit row.
//     If a wrong press and an expiring unhit tile coincide, misses += 2 and
//       miss_pulse is a single pulse.
//   Miss arithmetic: misses saturates at 15. The MAX_MISS compare is >=, so a
//     double miss can cross the threshold.
//   Pulses are asserted in PLAY only. The transition to OVER happens on the cycle
//     after the threshold is reached.
//   A state_change in IDLE or OVER is ignored; no row is pushed.
//   Reset mid-game returns the block to IDLE immediately and clears everything.
// STRUCTURE
//   Shared package piano_pkg holds: LANES=4, the FSM encodings
//     (IDLE=2'd0, PLAY=2'd1, OVER=2'd2), and an is_onehot4 function.
//     The display stage reuses the same package.
//   Sub-module btn_edge_detect (parameter W=4): the btn_q register plus the press logic.
//   Queue shift register, scoring logic and FSM are inline.
// TESTING
//   1. Reset, start=1, then push 0100 three times: rows 0..2 = 0100. Score 0, misses 0.
//   2. Push 0001 until it reaches row ROWS-1, then press btn=0001:
//      hit_pulse=1, score=1, row 7 = 0000.
//   3. Let a 1000 tile scroll out unpressed: miss_pulse=1, misses=1. Repeat twice:
//      game_over=1 on the cycle after misses=3, and rows stay frozen.
//   4. Press btn=0001 while the hit row is 0010 in the same cycle as state_change:
//      misses += 2, one miss_pulse, and the queue still shifts.
//   5. Push state=1010 (not one-hot): row 0 = 0000. Hold btn=0001 high for 5 cycles:
//      only one press is evaluated.
//   6. Assert rst mid-PLAY with score=5: all outputs are 0 asynchronously.
//      Release rst, start=1: play resumes from empty rows.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: lane count, game FSM encodings and lane-word helpers shared with the display stage
package piano_pkg;
    localparam int LANES = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} game_state_t;
    function automatic logic is_onehot4(input logic [3:0] v);
        return v != 4'd0 && (v & (v - 4'd1)) == 4'd0;
    endfunction
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registers the key levels and flags keys that went high this cycle
module btn_edge_detect #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn,
    output logic [W-1:0] press
);
    logic [W-1:0] btn_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) btn_q <= '0;
        else btn_q <= btn;
    assign press = btn & ~btn_q;
endmodule

// File: rtl/tile_lane_queue.sv
// tile_lane_queue: falling-tile row queue scored against key presses on the bottom row
module tile_lane_queue
    import piano_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int SCORE_W  = 10,
    parameter int MAX_MISS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      state,
    input  logic                  state_change,
    input  logic [LANES-1:0]      btn,
    input  logic                  start,
    output logic [LANES*ROWS-1:0] rows_flat,
    output logic [SCORE_W-1:0]    score,
    output logic [3:0]            misses,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  game_over
);
    game_state_t st, st_n;
    logic [LANES-1:0] rows [ROWS];
    logic [LANES-1:0] press, hit_row;
    logic play, hit, wrong, expire;
    logic [4:0] miss_sum;

    btn_edge_detect #(.W(LANES)) u_edge (.clk(clk), .rst(rst), .btn(btn), .press(press));

    assign play     = st == PLAY;
    assign hit_row  = rows[ROWS-1];
    // a non-zero press equal to the hit row implies the hit row is occupied
    assign hit      = play && press != '0 && press == hit_row;
    assign wrong    = play && press != '0 && !hit;
    assign expire   = play && state_change && hit_row != '0 && !hit;
    assign miss_sum = {1'b0, misses} + 5'(wrong) + 5'(expire);
    assign game_over = st == OVER;

    for (genvar r = 0; r < ROWS; r++) begin : g_flat
        assign rows_flat[LANES*r +: LANES] = rows[r];
    end

    always_comb begin
        st_n = st;
        if (st == IDLE && start) st_n = PLAY;
        else if (play && misses >= 4'(MAX_MISS)) st_n = OVER;
        else if (st == OVER && start) st_n = PLAY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            for (int i = 0; i < ROWS; i++) rows[i] <= '0;
        end else begin
            st         <= st_n;
            hit_pulse  <= hit;
            miss_pulse <= wrong | expire;
            if (st == OVER && start) begin
                score  <= '0;
                misses <= '0;
                for (int i = 0; i < ROWS; i++) rows[i] <= '0;
            end else if (play) begin
                if (hit && score != '1) score <= score + SCORE_W'(1);
                misses <= miss_sum > 5'd15 ? 4'd15 : miss_sum[3:0];
                if (state_change) begin
                    rows[0] <= is_onehot4(state) ? state : '0;
                    for (int i = 1; i < ROWS; i++) rows[i] <= rows[i-1];
                end else if (hit) begin
                    rows[ROWS-1] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tile_lane_queue.sv
// tb_tile_lane_queue: directed game scenarios plus random play against a behavioural game model
module tb_tile_lane_queue;
    localparam int ROWS = 8;
    localparam int SW   = 10;
    localparam int MM   = 3;

    logic clk = 1'b0;
    logic rst, start, state_change;
    logic [3:0] state, btn;
    logic [4*ROWS-1:0] rows_flat;
    logic [SW-1:0] score;
    logic [3:0] misses;
    logic hit_pulse, miss_pulse, game_over;

    tile_lane_queue #(.ROWS(ROWS), .SCORE_W(SW), .MAX_MISS(MM)) dut (
        .clk(clk), .rst(rst), .state(state), .state_change(state_change), .btn(btn),
        .start(start), .rows_flat(rows_flat), .score(score), .misses(misses),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int m_mode, m_score, m_misses;
    logic [3:0] m_rows [ROWS];
    logic [3:0] m_btn_q;
    logic m_hit, m_miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*ROWS-1:0] m_flat();
        logic [4*ROWS-1:0] f;
        for (int r = 0; r < ROWS; r++) f[4*r +: 4] = m_rows[r];
        return f;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_score = 0; m_misses = 0; m_btn_q = 0; m_hit = 0; m_miss = 0;
        for (int r = 0; r < ROWS; r++) m_rows[r] = 0;
    endtask

    task automatic m_step();
        logic [3:0] press, hr;
        logic hit;
        int n, nxt;
        press = btn & ~m_btn_q;
        m_btn_q = btn;
        m_hit = 0;
        m_miss = 0;
        if (m_mode == 1) begin
            hr  = m_rows[ROWS-1];
            hit = press != 0 && press == hr;
            n   = int'(press != 0 && !hit) + int'(state_change && hr != 0 && !hit);
            m_hit  = hit;
            m_miss = n > 0;
            nxt = m_misses >= MM ? 2 : 1;
            if (hit && m_score < (1 << SW) - 1) m_score++;
            m_misses = (m_misses + n > 15) ? 15 : m_misses + n;
            if (state_change) begin
                for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
                m_rows[0] = ($countones(state) == 1) ? state : 4'd0;
            end else if (hit) begin
                m_rows[ROWS-1] = 0;
            end
            m_mode = nxt;
        end else if (start) begin
            m_score = 0; m_misses = 0;
            for (int r = 0; r < ROWS; r++) m_rows[r] = 0;
            m_mode = 1;
        end
    endtask

    task automatic check_all();
        chk("rows_flat", rows_flat, m_flat());
        chk("score", score, m_score);
        chk("misses", misses, m_misses);
        chk("hit_pulse", hit_pulse, m_hit);
        chk("miss_pulse", miss_pulse, m_miss);
        chk("game_over", game_over, m_mode == 2);
    endtask

    task automatic step(input logic [3:0] s, input logic sc, input logic [3:0] b, input logic st);
        state = s; state_change = sc; btn = b; start = st;
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic push(input logic [3:0] s);
        step(s, 1'b1, 4'd0, 1'b0);
    endtask

    task automatic bring_to_hit(input logic [3:0] s);
        push(s);
        repeat (ROWS - 1) push(4'd0);
    endtask

    initial begin
        int np;
        logic [3:0] b;
        rst = 1'b1; start = 0; state_change = 0; state = 0; btn = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        chk("reset_rows", rows_flat, 0);
        chk("reset_over", game_over, 0);

        // three 0100 tiles at the top
        step(0, 0, 0, 1);
        repeat (3) push(4'b0100);
        chk("t1_rows", rows_flat[11:0], 12'h444);
        chk("t1_score", score, 0);

        @(negedge clk); rst = 1'b1; m_reset();
        @(negedge clk); rst = 1'b0;
        step(0, 0, 0, 1);

        // hit a 0001 tile on the bottom row
        bring_to_hit(4'b0001);
        step(0, 0, 4'b0001, 0);
        chk("t2_hit", hit_pulse, 1);
        chk("t2_score", score, 1);
        chk("t2_row7", rows_flat[31:28], 0);
        step(0, 0, 0, 0);

        // three unpressed tiles scroll out and end the game
        bring_to_hit(4'b1000);
        push(0);
        chk("t3_miss", miss_pulse, 1);
        chk("t3_misses", misses, 1);
        bring_to_hit(4'b1000);
        push(0);
        push(4'b1000);
        repeat (ROWS - 2) push(0);
        push(4'b0010);
        push(0);
        chk("t3_misses3", misses, 3);
        chk("t3_not_over_yet", game_over, 0);
        step(0, 0, 0, 0);
        chk("t3_over", game_over, 1);
        push(4'b0100);
        chk("t3_frozen", rows_flat, 32'h20);
        step(0, 0, 0, 1);
        chk("t3_restart", score, 0);

        // wrong press coinciding with an expiring tile
        push(4'b0010);
        push(4'b0100);
        repeat (ROWS - 2) push(0);
        step(0, 1, 4'b0001, 0);
        chk("t4_misses", misses, 2);
        chk("t4_pulse", miss_pulse, 1);
        chk("t4_shift", rows_flat[31:28], 4'b0100);
        step(0, 0, 0, 0);
        chk("t4_single_pulse", miss_pulse, 0);
        step(0, 0, 4'b0100, 0);
        step(0, 0, 0, 0);

        // non-one-hot push, then a held key counts once
        push(4'b1010);
        chk("t5_row0", rows_flat[3:0], 0);
        np = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'b0001, 0);
            np += int'(miss_pulse);
        end
        chk("t5_one_press", np, 1);
        step(0, 0, 0, 0);

        // score 5, then asynchronous reset mid-game
        step(0, 0, 0, 1);
        repeat (5) begin
            bring_to_hit(4'b0001);
            step(0, 0, 4'b0001, 0);
            step(0, 0, 0, 0);
        end
        chk("t6_score5", score, 5);
        push(4'b0100);
        rst = 1'b1;
        #1;
        chk("t6_async_rows", rows_flat, 0);
        chk("t6_async_score", score, 0);
        chk("t6_async_misses", misses, 0);
        chk("t6_async_over", game_over, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1);
        push(4'b0001);
        chk("t6_resume", rows_flat, 32'h1);

        b = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] s;
            s = ($urandom % 4 == 0) ? 4'($urandom) : 4'(1 << ($urandom % 4));
            if ($urandom % 3 == 0) b = ($urandom % 2) ? 4'(1 << ($urandom % 4)) : ($urandom % 4 == 0 ? 4'($urandom) : 4'd0);
            step(s, $urandom % 3 == 0, b, $urandom % 40 == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
